host_link_responder: RTL

- Device-side end of the cracker's byte-wide host handshake (new_hash_byte / store_hash_byte / go / my_turn / match_found / password_byte).
- Assembles 16-byte target hashes and writes them into the hash store.
- Starts and resumes the cracking core.
- Serialises each found password back to the host: 20 password bytes, then one length byte.
- Sits between the board pins and the hash checker / password generator.

---
 rtl/host_link_responder.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/host_link_responder.sv
// host_link_responder: device-side end of the byte-wide host handshake.
// Assembles 16-byte target hashes for the hash store, starts/resumes the
// cracking core and streams each found password back one byte per go strobe.
module host_link_responder #(
  parameter int MAX_HASHES = 2,
  parameter int IDX_W      = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         new_hash_byte,
  input  logic               store_hash_byte,
  input  logic               go,
  output logic               my_turn,
  output logic               match_found,
  output logic [7:0]         password_byte,
  output logic [127:0]       hash_data,
  output logic [IDX_W-1:0]   hash_index,
  output logic               hash_write,
  output logic               hash_clear,
  output logic [IDX_W:0]     hash_count,
  output logic               crack_start,
  output logic               crack_resume,
  input  logic               core_done,
  input  logic               core_match,
  input  logic [159:0]       core_password,
  input  logic [7:0]         core_length,
  output logic               hash_overflow
);

  typedef enum logic [2:0] {
    ST_LOAD      = 3'd0,
    ST_ACK       = 3'd1,
    ST_CRACK     = 3'd2,
    ST_REPORT    = 3'd3,
    ST_RWAIT     = 3'd4,
    ST_EXHAUSTED = 3'd5
  } state_t;

  localparam logic [IDX_W:0] MAX_CNT  = (IDX_W+1)'(MAX_HASHES);
  localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [4:0]     LAST_K   = 5'd20;

  state_t         state_r;
  logic           store_r;
  logic           store_d_r;
  logic           go_r;
  logic           go_d_r;
  logic           store_ev_s;
  logic           go_ev_s;
  logic [3:0]     byte_cnt_r;
  logic [4:0]     k_r;
  logic [159:0]   pw_r;
  logic [7:0]     len_r;

  // Report byte k: password bytes 19 down to 0 for k=0..19, then the length.
  function automatic logic [7:0] report_byte(input logic [159:0] pw,
                                             input logic [7:0]   len,
                                             input logic [4:0]   k);
    logic [7:0] b;
    b = len;
    for (int i = 0; i < 20; i++) begin
      if (k == 5'(i)) begin
        b = pw[8*(19-i) +: 8];
      end
    end
    return b;
  endfunction

  // Single register stage on the host strobes; reset high so a line held
  // high through reset does not look like a fresh rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      store_r   <= 1'b1;
      store_d_r <= 1'b1;
      go_r      <= 1'b1;
      go_d_r    <= 1'b1;
    end else begin
      store_r   <= store_hash_byte;
      store_d_r <= store_r;
      go_r      <= go;
      go_d_r    <= go_r;
    end
  end

  assign store_ev_s = store_r & ~store_d_r;
  assign go_ev_s    = go_r & ~go_d_r;

  // Handshake FSM with registered outputs and single-cycle command pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_LOAD;
      my_turn       <= 1'b1;
      match_found   <= 1'b0;
      password_byte <= 8'h00;
      hash_data     <= 128'h0;
      hash_index    <= '0;
      hash_write    <= 1'b0;
      hash_clear    <= 1'b0;
      hash_count    <= '0;
      crack_start   <= 1'b0;
      crack_resume  <= 1'b0;
      hash_overflow <= 1'b0;
      byte_cnt_r    <= 4'd0;
      k_r           <= 5'd0;
      pw_r          <= 160'h0;
      len_r         <= 8'h00;
    end else begin
      hash_write   <= 1'b0;
      hash_clear   <= 1'b0;
      crack_start  <= 1'b0;
      crack_resume <= 1'b0;
      case (state_r)
        ST_LOAD: begin
          if (store_ev_s) begin
            // Store wins over a simultaneous go.
            state_r <= ST_ACK;
            my_turn <= 1'b0;
            if (hash_count == MAX_CNT) begin
              hash_overflow <= 1'b1;
            end else begin
              hash_data[{byte_cnt_r, 3'b000} +: 8] <= new_hash_byte;
              if (byte_cnt_r == 4'd15) begin
                hash_write <= 1'b1;
                hash_index <= hash_count[IDX_W-1:0];
                hash_count <= hash_count + CNT_ONE;
                byte_cnt_r <= 4'd0;
              end else begin
                byte_cnt_r <= byte_cnt_r + 4'd1;
              end
            end
          end else if (go_ev_s) begin
            byte_cnt_r <= 4'd0;
            if (hash_count != '0) begin
              crack_start <= 1'b1;
              my_turn     <= 1'b0;
              state_r     <= ST_CRACK;
            end else begin
              state_r     <= ST_EXHAUSTED;
            end
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_ACK: begin
          if (!store_r) begin
            state_r <= ST_LOAD;
            my_turn <= 1'b1;
          end else begin
            state_r <= ST_ACK;
          end
        end
        ST_CRACK: begin
          if (core_done && core_match) begin
            pw_r          <= core_password;
            len_r         <= core_length;
            k_r           <= 5'd0;
            password_byte <= core_password[159:152];
            match_found   <= 1'b1;
            my_turn       <= 1'b1;
            state_r       <= ST_REPORT;
          end else if (core_done) begin
            password_byte <= 8'h00;
            match_found   <= 1'b0;
            my_turn       <= 1'b1;
            state_r       <= ST_EXHAUSTED;
          end else begin
            state_r <= ST_CRACK;
          end
        end
        ST_REPORT: begin
          if (go_ev_s) begin
            my_turn <= 1'b0;
            state_r <= ST_RWAIT;
          end else begin
            state_r <= ST_REPORT;
          end
        end
        ST_RWAIT: begin
          if (!go_r) begin
            if (k_r < LAST_K) begin
              k_r           <= k_r + 5'd1;
              password_byte <= report_byte(pw_r, len_r, k_r + 5'd1);
              my_turn       <= 1'b1;
              state_r       <= ST_REPORT;
            end else begin
              crack_resume  <= 1'b1;
              match_found   <= 1'b0;
              password_byte <= 8'h00;
              state_r       <= ST_CRACK;
            end
          end else begin
            state_r <= ST_RWAIT;
          end
        end
        ST_EXHAUSTED: begin
          if (go_ev_s) begin
            hash_clear    <= 1'b1;
            hash_count    <= '0;
            hash_overflow <= 1'b0;
            byte_cnt_r    <= 4'd0;
            state_r       <= ST_LOAD;
          end else begin
            state_r <= ST_EXHAUSTED;
          end
        end
        default: begin
          state_r     <= ST_LOAD;
          my_turn     <= 1'b1;
          match_found <= 1'b0;
        end
      endcase
    end
  end

endmodule
